// File: rtl/cache_types_pkg.sv
// Shared types for the two-core coherent cache system: MESI states, bus ops, snoop-bus FSM.
package cache_types;

   localparam int unsigned LINE_W = 256;

   typedef enum logic [1:0] {
      INVALID   = 2'b00,
      SHARED    = 2'b01,
      EXCLUSIVE = 2'b10,
      MODIFIED  = 2'b11
   } mesi_state_t;

   typedef enum logic [1:0] {
      NONE     = 2'b00,
      BUS_RD   = 2'b01,
      BUS_RDX  = 2'b10,
      BUS_UPGR = 2'b11
   } bus_op_t;

   typedef enum logic [2:0] {
      IDLE,
      SNOOP,
      MEM_RD,
      WB,
      RESP
   } bus_fsm_t;

endpackage

// File: rtl/snoop_bus_ctrl_arb.sv
// 2-way round-robin arbiter: the pointer core wins when requesting, else the other core.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       advance,
   input  logic       ptr,
   output logic [1:0] grant
);

   // One-hot grant, only while the bus is free to accept a request
   always_comb begin
      grant = 2'b00;
      if (advance) begin
         if (req[ptr]) begin
            grant = ptr ? 2'b10 : 2'b01;
         end else if (req[!ptr]) begin
            grant = ptr ? 2'b01 : 2'b10;
         end
      end
   end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Shared snoop-bus controller: arbitrates two cores, snoops the peer, and completes
// each transaction by cache-to-cache transfer, memory read, or writeback-then-forward.
module snoop_bus_ctrl
   import cache_types::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             req_valid,
   input  logic [1:0][1:0]        req_op,
   input  logic [1:0][ADDR_W-1:0] req_addr,
   output logic [1:0]             req_grant,
   output logic [1:0]             resp_valid,
   output logic [LINE_W-1:0]      resp_data,
   output logic [1:0]             resp_state,
   output logic [1:0]             snp_valid,
   output logic [1:0]             snp_op,
   output logic [ADDR_W-1:0]      snp_addr,
   input  logic [1:0]             snp_ack,
   input  logic [1:0]             snp_match,
   input  logic [1:0][1:0]        snp_state,
   input  logic [1:0][LINE_W-1:0] snp_data,
   output logic                   mem_read,
   output logic                   mem_write,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [LINE_W-1:0]      mem_wdata,
   input  logic [LINE_W-1:0]      mem_rdata,
   input  logic                   mem_resp
);

   bus_fsm_t          state_q, state_d;
   logic              ptr_q, ptr_d;
   logic              core_q, core_d;
   bus_op_t           op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] line_q, line_d;
   mesi_state_t       rstate_q, rstate_d;

   logic              peer;
   mesi_state_t       peer_state;
   logic              peer_hit;
   logic              arb_adv;
   logic [1:0]        grant;

   // Snooped core is always the one that did not win the bus
   assign peer       = !core_q;
   assign peer_state = mesi_state_t'(snp_state[peer]);
   assign peer_hit   = snp_match[peer] && (peer_state != INVALID);
   assign arb_adv    = (state_q == IDLE) && !rst;

   rr_arb2 u_arb (
      .req     (req_valid),
      .advance (arb_adv),
      .ptr     (ptr_q),
      .grant   (grant)
   );

   // Next-state and latch updates; snoop outcome decides the completion path
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      core_d   = core_q;
      op_d     = op_q;
      addr_d   = addr_q;
      line_d   = line_q;
      rstate_d = rstate_q;
      case (state_q)
         IDLE: begin
            if (grant != 2'b00) begin
               core_d  = grant[1];
               op_d    = bus_op_t'(req_op[grant[1]]);
               addr_d  = req_addr[grant[1]];
               state_d = SNOOP;
            end
         end
         SNOOP: begin
            if (snp_ack[peer]) begin
               case (op_q)
                  BUS_UPGR: begin
                     rstate_d = MODIFIED;
                     state_d  = RESP;
                  end
                  BUS_RDX: begin
                     rstate_d = MODIFIED;
                     if (peer_hit) begin
                        line_d  = snp_data[peer];
                        state_d = RESP;
                     end else begin
                        state_d = MEM_RD;
                     end
                  end
                  default: begin
                     if (peer_hit) begin
                        line_d   = snp_data[peer];
                        rstate_d = SHARED;
                        state_d  = (peer_state == MODIFIED) ? WB : RESP;
                     end else begin
                        rstate_d = EXCLUSIVE;
                        state_d  = MEM_RD;
                     end
                  end
               endcase
            end
         end
         MEM_RD: begin
            if (mem_resp) begin
               line_d  = mem_rdata;
               state_d = RESP;
            end
         end
         WB: begin
            if (mem_resp) begin
               state_d = RESP;
            end
         end
         RESP: begin
            ptr_d   = !core_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and transaction latches; reset abandons any transaction in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= 1'b0;
         core_q   <= 1'b0;
         op_q     <= NONE;
         addr_q   <= '0;
         line_q   <= '0;
         rstate_q <= INVALID;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         core_q   <= core_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         line_q   <= line_d;
         rstate_q <= rstate_d;
      end
   end

   // Bus outputs decoded from the state register; payloads zeroed when not active
   assign req_grant  = grant;
   assign snp_valid  = (state_q == SNOOP) ? (core_q ? 2'b01 : 2'b10) : 2'b00;
   assign snp_op     = (state_q == SNOOP) ? op_q : NONE;
   assign snp_addr   = (state_q == SNOOP) ? addr_q : '0;
   assign mem_read   = (state_q == MEM_RD);
   assign mem_write  = (state_q == WB);
   assign mem_addr   = ((state_q == MEM_RD) || (state_q == WB)) ? addr_q : '0;
   assign mem_wdata  = (state_q == WB) ? line_q : '0;
   assign resp_valid = (state_q == RESP) ? (core_q ? 2'b10 : 2'b01) : 2'b00;
   assign resp_data  = (state_q == RESP) ? line_q : '0;
   assign resp_state = (state_q == RESP) ? rstate_q : INVALID;

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Directed bench for snoop_bus_ctrl: memory miss, dirty writeback, c2c transfer,
// upgrade, round-robin fairness, and reset mid-transaction.
module tb_snoop_bus_ctrl;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned LINE_W = 256;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [1:0]             req_valid;
   logic [1:0][1:0]        req_op;
   logic [1:0][ADDR_W-1:0] req_addr;
   logic [1:0]             req_grant;
   logic [1:0]             resp_valid;
   logic [LINE_W-1:0]      resp_data;
   logic [1:0]             resp_state;
   logic [1:0]             snp_valid;
   logic [1:0]             snp_op;
   logic [ADDR_W-1:0]      snp_addr;
   logic [1:0]             snp_ack;
   logic [1:0]             snp_match;
   logic [1:0][1:0]        snp_state;
   logic [1:0][LINE_W-1:0] snp_data;
   logic                   mem_read;
   logic                   mem_write;
   logic [ADDR_W-1:0]      mem_addr;
   logic [LINE_W-1:0]      mem_wdata;
   logic [LINE_W-1:0]      mem_rdata;
   logic                   mem_resp;

   int total = 0;
   int bad   = 0;

   logic [LINE_W-1:0] line_aa, line_55, line_33;
   logic [1:0]        exp_g;

   snoop_bus_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_grant  (req_grant),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_state (resp_state),
      .snp_valid  (snp_valid),
      .snp_op     (snp_op),
      .snp_addr   (snp_addr),
      .snp_ack    (snp_ack),
      .snp_match  (snp_match),
      .snp_state  (snp_state),
      .snp_data   (snp_data),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_resp   (mem_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive point: just after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sample point: falling edge
   task automatic smp();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      req_valid = 2'b00;
      req_op    = '0;
      req_addr  = '0;
      snp_ack   = 2'b00;
      snp_match = 2'b00;
      snp_state = '0;
      snp_data  = '0;
      mem_rdata = '0;
      mem_resp  = 1'b0;
   endtask

   initial begin
      line_aa = {32{8'hAA}};
      line_55 = {32{8'h55}};
      line_33 = {32{8'h33}};
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();

      // Reset state
      smp();
      chk("rst_grant", 256'(req_grant), 256'(2'b00));
      chk("rst_resp_valid", 256'(resp_valid), 256'(2'b00));
      chk("rst_snp_valid", 256'(snp_valid), 256'(2'b00));
      chk("rst_mem_rw", 256'({mem_read, mem_write}), 256'(2'b00));
      chk("rst_resp_data", resp_data, 256'(0));
      rst = 1'b0;
      tick();

      // Core0 BUS_RD miss -> memory read -> EXCLUSIVE
      req_valid = 2'b01; req_op[0] = 2'b01; req_addr[0] = 32'h40;
      smp();
      chk("t1_grant", 256'(req_grant), 256'(2'b01));
      tick();
      snp_ack = 2'b10; snp_match = 2'b00;
      smp();
      chk("t1_snp_valid", 256'(snp_valid), 256'(2'b10));
      chk("t1_snp_op", 256'(snp_op), 256'(2'b01));
      chk("t1_snp_addr", 256'(snp_addr), 256'(32'h40));
      chk("t1_no_regrant", 256'(req_grant), 256'(2'b00));
      tick();
      snp_ack = 2'b00;
      smp();
      chk("t1_mem_read", 256'(mem_read), 256'(1'b1));
      chk("t1_mem_addr", 256'(mem_addr), 256'(32'h40));
      chk("t1_snp_drop", 256'(snp_valid), 256'(2'b00));
      tick();
      mem_resp = 1'b1; mem_rdata = line_aa;
      smp();
      chk("t1_mem_read_hold", 256'(mem_read), 256'(1'b1));
      chk("t1_no_early_resp", 256'(resp_valid), 256'(2'b00));
      tick();
      mem_resp = 1'b0; mem_rdata = '0; req_valid = 2'b00;
      smp();
      chk("t1_resp_valid", 256'(resp_valid), 256'(2'b01));
      chk("t1_resp_data", resp_data, line_aa);
      chk("t1_resp_state", 256'(resp_state), 256'(2'b10));
      chk("t1_mem_read_off", 256'(mem_read), 256'(1'b0));
      tick();
      smp();
      chk("t1_resp_pulse", 256'(resp_valid), 256'(2'b00));
      tick();

      // Core1 BUS_RD hits MODIFIED -> writeback then forward as SHARED
      req_valid = 2'b10; req_op[1] = 2'b01; req_addr[1] = 32'h80;
      smp();
      chk("t2_grant", 256'(req_grant), 256'(2'b10));
      tick();
      snp_ack = 2'b01; snp_match = 2'b01; snp_state[0] = 2'b11; snp_data[0] = line_55;
      smp();
      chk("t2_snp_valid", 256'(snp_valid), 256'(2'b01));
      tick();
      clear_inputs(); req_valid = 2'b10; req_op[1] = 2'b01; req_addr[1] = 32'h80;
      smp();
      chk("t2_mem_write", 256'(mem_write), 256'(1'b1));
      chk("t2_mem_read", 256'(mem_read), 256'(1'b0));
      chk("t2_mem_wdata", mem_wdata, line_55);
      chk("t2_mem_addr", 256'(mem_addr), 256'(32'h80));
      tick();
      mem_resp = 1'b1;
      smp();
      chk("t2_mem_write_hold", 256'(mem_write), 256'(1'b1));
      tick();
      mem_resp = 1'b0; req_valid = 2'b00;
      smp();
      chk("t2_resp_valid", 256'(resp_valid), 256'(2'b10));
      chk("t2_resp_data", resp_data, line_55);
      chk("t2_resp_state", 256'(resp_state), 256'(2'b01));
      tick();

      // Core0 BUS_RDX hits EXCLUSIVE -> direct transfer, MODIFIED
      req_valid = 2'b01; req_op[0] = 2'b10; req_addr[0] = 32'hC0;
      smp();
      chk("t3_grant", 256'(req_grant), 256'(2'b01));
      tick();
      snp_ack = 2'b10; snp_match = 2'b10; snp_state[1] = 2'b10; snp_data[1] = line_33;
      smp();
      chk("t3_snp_op", 256'(snp_op), 256'(2'b10));
      tick();
      clear_inputs();
      smp();
      chk("t3_resp_valid", 256'(resp_valid), 256'(2'b01));
      chk("t3_resp_data", resp_data, line_33);
      chk("t3_resp_state", 256'(resp_state), 256'(2'b11));
      chk("t3_no_mem", 256'({mem_read, mem_write}), 256'(2'b00));
      tick();

      // Core1 BUS_UPGR -> response the cycle after the ack, MODIFIED
      req_valid = 2'b10; req_op[1] = 2'b11; req_addr[1] = 32'h100;
      smp();
      chk("t4_grant", 256'(req_grant), 256'(2'b10));
      tick();
      snp_ack = 2'b01;
      smp();
      tick();
      clear_inputs();
      smp();
      chk("t4_resp_valid", 256'(resp_valid), 256'(2'b10));
      chk("t4_resp_state", 256'(resp_state), 256'(2'b11));
      chk("t4_no_mem", 256'({mem_read, mem_write}), 256'(2'b00));
      tick();

      // Both cores request continuously after reset -> grants alternate 0,1,0,1
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req_valid = 2'b11; req_op[0] = 2'b11; req_op[1] = 2'b11;
      for (int t = 0; t < 4; t++) begin
         exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
         smp();
         chk("rr_grant", 256'(req_grant), 256'(exp_g));
         tick();
         snp_ack = exp_g[0] ? 2'b10 : 2'b01;
         smp();
         chk("rr_no_regrant_snoop", 256'(req_grant), 256'(2'b00));
         tick();
         snp_ack = 2'b00;
         smp();
         chk("rr_resp", 256'(resp_valid), 256'(exp_g));
         chk("rr_no_regrant_resp", 256'(req_grant), 256'(2'b00));
         tick();
      end
      clear_inputs();

      // Core0 upgrade moves the pointer to core1
      req_valid = 2'b01; req_op[0] = 2'b11;
      smp();
      chk("t6_pre_grant", 256'(req_grant), 256'(2'b01));
      tick();
      snp_ack = 2'b10;
      smp();
      tick();
      clear_inputs();
      smp();
      chk("t6_pre_resp", 256'(resp_valid), 256'(2'b01));
      tick();

      // Core1 read miss, reset while in MEM_RD
      req_valid = 2'b10; req_op[1] = 2'b01; req_addr[1] = 32'h200;
      smp();
      chk("t6_grant", 256'(req_grant), 256'(2'b10));
      tick();
      snp_ack = 2'b01;
      smp();
      tick();
      snp_ack = 2'b00;
      smp();
      chk("t6_mem_read", 256'(mem_read), 256'(1'b1));
      rst = 1'b1; req_valid = 2'b00;
      tick();
      smp();
      chk("t6_rst_mem_read", 256'(mem_read), 256'(1'b0));
      chk("t6_rst_mem_addr", 256'(mem_addr), 256'(0));
      chk("t6_rst_resp_valid", 256'(resp_valid), 256'(2'b00));
      chk("t6_rst_snp_valid", 256'(snp_valid), 256'(2'b00));
      chk("t6_rst_grant", 256'(req_grant), 256'(2'b00));
      rst = 1'b0;
      tick();
      smp();
      chk("t6_after_resp_valid", 256'(resp_valid), 256'(2'b00));
      chk("t6_after_mem_read", 256'(mem_read), 256'(1'b0));
      tick();
      req_valid = 2'b11; req_op[0] = 2'b01; req_op[1] = 2'b01;
      smp();
      chk("t6_ptr_reset_grant", 256'(req_grant), 256'(2'b01));
      tick();
      clear_inputs();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
